// File: rtl/vga_pmod_colorizer_pkg.sv
// quine_vga_pkg: PMOD bit order, RGB222 colour type and palette constants
package quine_vga_pkg;
   localparam int PMOD_HS = 7;
   localparam int PMOD_B0 = 6;
   localparam int PMOD_G0 = 5;
   localparam int PMOD_R0 = 4;
   localparam int PMOD_VS = 3;
   localparam int PMOD_B1 = 2;
   localparam int PMOD_G1 = 1;
   localparam int PMOD_R1 = 0;
   typedef struct packed {
      logic [1:0] r;
      logic [1:0] g;
      logic [1:0] b;
   } rgb222_t;
   typedef enum logic [1:0] {PAL_WHITE, PAL_GREEN, PAL_AMBER, PAL_RAINBOW} pal_e;
   localparam rgb222_t BLACK = 6'b00_00_00;
   localparam rgb222_t WHITE = 6'b11_11_11;
   localparam rgb222_t GREEN = 6'b00_11_00;
   localparam rgb222_t AMBER = 6'b11_10_00;
   localparam rgb222_t RAINBOW [8] = '{
      6'b11_00_00, 6'b11_10_00, 6'b11_11_00, 6'b00_11_00,
      6'b00_11_11, 6'b00_00_11, 6'b10_00_11, 6'b11_00_11
   };
   // Place syncs and colour bits onto the TinyTapeout VGA PMOD pin order
   function automatic logic [7:0] pack_pmod(input logic hs, input logic vs, input rgb222_t c);
      logic [7:0] o;
      o = '0;
      o[PMOD_HS] = hs;
      o[PMOD_VS] = vs;
      o[PMOD_R1] = c.r[1];
      o[PMOD_R0] = c.r[0];
      o[PMOD_G1] = c.g[1];
      o[PMOD_G0] = c.g[0];
      o[PMOD_B1] = c.b[1];
      o[PMOD_B0] = c.b[0];
      return o;
   endfunction
endpackage

// File: rtl/vga_pmod_colorizer_sync_edge_det.sv
// sync_edge_det: registers an active-low sync and flags its falling edge
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_in,
   output logic sync_o,
   output logic fall
);
   logic sync_d, sync_q;
   // Next sample and falling-edge pulse against the previous sample
   always_comb begin
      sync_d = sync_in;
      fall   = sync_q & ~sync_in;
   end
   // Sync register idles inactive (high) out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 1'b1;
      else        sync_q <= sync_d;
   end
   assign sync_o = sync_q;
endmodule

// File: rtl/vga_pmod_colorizer.sv
// vga_pmod_colorizer: realigns pixel to syncs, applies a palette, drives the VGA PMOD
module vga_pmod_colorizer
   import quine_vga_pkg::*;
#(
   parameter int BAND_SHIFT = 3,
   parameter int FRAME_STEP = 8,
   parameter int LINE_W     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       pix_in,
   input  logic [1:0] pal_sel,
   output logic [7:0] uo_out
);
   logic              hs_q, vs_q, line_tick, frame_tick, frame_wrap;
   logic              pix1_d, pix1_q, pix2_d, pix2_q;
   logic [LINE_W-1:0] line_cnt_d, line_cnt_q;
   logic [7:0]        frame_cnt_d, frame_cnt_q, uo_d, uo_q;
   logic [2:0]        phase_d, phase_q, band;
   pal_e              pal_d, pal_q;
   rgb222_t           colour;

   sync_edge_det u_hs (.clk(clk), .rst_n(rst_n), .sync_in(hsync_in), .sync_o(hs_q), .fall(line_tick));
   sync_edge_det u_vs (.clk(clk), .rst_n(rst_n), .sync_in(vsync_in), .sync_o(vs_q), .fall(frame_tick));

   // Pixel delay line, scanline/frame counters and frame-latched palette select
   always_comb begin
      pix1_d      = pix_in;
      pix2_d      = pix1_q;
      line_cnt_d  = frame_tick ? '0 :
                    (line_tick && line_cnt_q != '1) ? line_cnt_q + 1'b1 : line_cnt_q;
      frame_wrap  = frame_tick && frame_cnt_q == 8'(FRAME_STEP - 1);
      frame_cnt_d = !frame_tick ? frame_cnt_q : frame_wrap ? '0 : frame_cnt_q + 1'b1;
      phase_d     = phase_q + 3'(frame_wrap);
      pal_d       = frame_tick ? pal_e'(pal_sel) : pal_q;
   end

   // Colour lookup for the delayed pixel, packed with the delayed syncs
   always_comb begin
      band   = 3'(line_cnt_q >> BAND_SHIFT) + phase_q;
      colour = !pix2_q              ? BLACK :
               pal_q == PAL_WHITE   ? WHITE :
               pal_q == PAL_GREEN   ? GREEN :
               pal_q == PAL_AMBER   ? AMBER : RAINBOW[band];
      uo_d   = pack_pmod(hs_q, vs_q, colour);
   end

   // State registers; output idles with both syncs inactive
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix1_q      <= 1'b0;
         pix2_q      <= 1'b0;
         line_cnt_q  <= '0;
         frame_cnt_q <= '0;
         phase_q     <= '0;
         pal_q       <= PAL_WHITE;
         uo_q        <= 8'h88;
      end else begin
         pix1_q      <= pix1_d;
         pix2_q      <= pix2_d;
         line_cnt_q  <= line_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
         pal_q       <= pal_d;
         uo_q        <= uo_d;
      end
   end

   assign uo_out = uo_q;
endmodule
